// File: rtl/traffic_countdown_ctrl_pkg.sv
// Shared types for the intersection sequencer: phase states, lamp codes and
// the registered output bundle driven toward the 7-segment display driver.
package traffic_countdown_ctrl_pkg;

  localparam int unsigned CNT_W  = 5;
  localparam int unsigned LAMP_W = 3;

  typedef enum logic [2:0] {
    A_GREEN  = 3'd0,
    A_YELLOW = 3'd1,
    B_GREEN  = 3'd2,
    B_YELLOW = 3'd3,
    NIGHT    = 3'd4
  } state_e;

  // Lamp vectors are {R,Y,G}
  localparam logic [LAMP_W-1:0] LAMP_R   = 3'b100;
  localparam logic [LAMP_W-1:0] LAMP_Y   = 3'b010;
  localparam logic [LAMP_W-1:0] LAMP_G   = 3'b001;
  localparam logic [LAMP_W-1:0] LAMP_OFF = 3'b000;

  typedef struct packed {
    logic [LAMP_W-1:0] light_a;
    logic [LAMP_W-1:0] light_b;
    logic              lr;
    logic              en_a;
    logic              en_b;
  } phase_out_t;

  // Day-cycle successor; NIGHT always resumes at the start of road A green.
  function automatic state_e next_phase(input state_e s);
    state_e n;
    case (s)
      A_GREEN:  n = A_YELLOW;
      A_YELLOW: n = B_GREEN;
      B_GREEN:  n = B_YELLOW;
      default:  n = A_GREEN;
    endcase
    return n;
  endfunction

  // Lamp/enable pattern for a state; lr_hold keeps the right-of-way flag in NIGHT.
  function automatic phase_out_t phase_outputs(input state_e s, input logic flash,
                                               input logic lr_hold);
    phase_out_t o;
    o.light_a = LAMP_R;
    o.light_b = LAMP_R;
    o.lr      = 1'b0;
    o.en_a    = 1'b0;
    o.en_b    = 1'b0;
    case (s)
      A_GREEN: begin
        o.light_a = LAMP_G;
        o.en_a    = 1'b1;
      end
      A_YELLOW: begin
        o.light_a = LAMP_Y;
        o.en_a    = 1'b1;
      end
      B_GREEN: begin
        o.light_b = LAMP_G;
        o.lr      = 1'b1;
        o.en_b    = 1'b1;
      end
      B_YELLOW: begin
        o.light_b = LAMP_Y;
        o.lr      = 1'b1;
        o.en_b    = 1'b1;
      end
      default: begin
        o.light_a = {1'b0, flash, 1'b0};
        o.light_b = {1'b0, flash, 1'b0};
        o.lr      = lr_hold;
      end
    endcase
    return o;
  endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Divides clk1 down to a one-cycle tick every TICK_DIV cycles; clr restarts
// the count so the next tick lands a full period later.
module tick_prescaler #(
  parameter int unsigned TICK_DIV = 50000000
) (
  input  logic clk1,
  input  logic rst_n,
  input  logic clr,
  output logic tick
);

  localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] LAST = PW'(TICK_DIV - 1);

  logic [PW-1:0] cnt_q;
  logic [PW-1:0] cnt_d;

  assign tick = (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q + PW'(1);
    if (clr || tick) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/traffic_countdown_ctrl.sv
// Two-road traffic-light sequencer with per-phase countdown and night
// flashing-yellow mode; all outputs are registered alongside the state.
module traffic_countdown_ctrl
  import traffic_countdown_ctrl_pkg::*;
#(
  parameter int unsigned TICK_DIV = 50000000,
  parameter int unsigned GREEN_T  = 20,
  parameter int unsigned YELLOW_T = 3
) (
  input  logic              clk1,
  input  logic              rst_n,
  input  logic              night,
  output logic [CNT_W-1:0]  Count,
  output logic              eLED01,
  output logic              eLED23,
  output logic              LR1,
  output logic [LAMP_W-1:0] lightA,
  output logic [LAMP_W-1:0] lightB
);

  if (TICK_DIV < 2) begin : g_bad_tick_div
    $error("traffic_countdown_ctrl: TICK_DIV must be >= 2");
  end
  if (GREEN_T < 1 || GREEN_T > 24) begin : g_bad_green
    $error("traffic_countdown_ctrl: GREEN_T must be 1..24");
  end
  if (YELLOW_T < 1 || YELLOW_T > 24) begin : g_bad_yellow
    $error("traffic_countdown_ctrl: YELLOW_T must be 1..24");
  end
  if (GREEN_T + YELLOW_T > 24) begin : g_bad_sum
    $error("traffic_countdown_ctrl: GREEN_T + YELLOW_T must be <= 24");
  end

  localparam logic [CNT_W-1:0] GREEN_C  = CNT_W'(GREEN_T);
  localparam logic [CNT_W-1:0] YELLOW_C = CNT_W'(YELLOW_T);
  localparam logic [CNT_W-1:0] ONE_C    = CNT_W'(1);

  localparam phase_out_t RESET_OUT = '{
    light_a: LAMP_G,
    light_b: LAMP_R,
    lr:      1'b0,
    en_a:    1'b1,
    en_b:    1'b0
  };

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             flash_q, flash_d;
  phase_out_t       out_q, out_d;
  logic             tick;
  logic             presc_clr;

  tick_prescaler #(
    .TICK_DIV (TICK_DIV)
  ) u_prescaler (
    .clk1  (clk1),
    .rst_n (rst_n),
    .clr   (presc_clr),
    .tick  (tick)
  );

  function automatic logic [CNT_W-1:0] phase_len(input state_e s);
    return (s == A_GREEN || s == B_GREEN) ? GREEN_C : YELLOW_C;
  endfunction

  // Night transitions take priority over, and swallow, a coincident tick.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    flash_d   = flash_q;
    presc_clr = 1'b0;
    if (state_q == NIGHT) begin
      if (!night) begin
        state_d   = A_GREEN;
        cnt_d     = GREEN_C;
        flash_d   = 1'b0;
        presc_clr = 1'b1;
      end else if (tick) begin
        flash_d = ~flash_q;
      end
    end else if (night) begin
      state_d   = NIGHT;
      cnt_d     = '0;
      flash_d   = 1'b0;
      presc_clr = 1'b1;
    end else if (tick) begin
      if (cnt_q > ONE_C) begin
        cnt_d = cnt_q - ONE_C;
      end else begin
        state_d = next_phase(state_q);
        cnt_d   = phase_len(state_d);
      end
    end
    out_d = phase_outputs(state_d, flash_d, out_q.lr);
  end

  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= A_GREEN;
      cnt_q   <= GREEN_C;
      flash_q <= 1'b0;
      out_q   <= RESET_OUT;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      flash_q <= flash_d;
      out_q   <= out_d;
    end
  end

  assign Count  = cnt_q;
  assign eLED01 = out_q.en_a;
  assign eLED23 = out_q.en_b;
  assign LR1    = out_q.lr;
  assign lightA = out_q.light_a;
  assign lightB = out_q.light_b;

endmodule

// File: tb/tb_traffic_countdown_ctrl.sv
// Directed bench: TICK_DIV=4, GREEN_T=5, YELLOW_T=2 main instance plus a
// YELLOW_T=1 instance for the short-yellow variant.
module tb_traffic_countdown_ctrl;
  import traffic_countdown_ctrl_pkg::*;

  logic       clk1;
  logic       rst_n;
  logic       night;
  logic [4:0] Count,  y_Count;
  logic       eLED01, y_eLED01;
  logic       eLED23, y_eLED23;
  logic       LR1,    y_LR1;
  logic [2:0] lightA, y_lightA;
  logic [2:0] lightB, y_lightB;

  int unsigned n_cmp;
  int unsigned n_err;
  int unsigned cur;

  traffic_countdown_ctrl #(.TICK_DIV(4), .GREEN_T(5), .YELLOW_T(2)) dut (
    .clk1(clk1), .rst_n(rst_n), .night(night), .Count(Count),
    .eLED01(eLED01), .eLED23(eLED23), .LR1(LR1),
    .lightA(lightA), .lightB(lightB)
  );

  traffic_countdown_ctrl #(.TICK_DIV(4), .GREEN_T(5), .YELLOW_T(1)) dut_y1 (
    .clk1(clk1), .rst_n(rst_n), .night(night), .Count(y_Count),
    .eLED01(y_eLED01), .eLED23(y_eLED23), .LR1(y_LR1),
    .lightA(y_lightA), .lightB(y_lightB)
  );

  initial clk1 = 1'b0;
  always #5 clk1 = ~clk1;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  typedef struct {
    bit          rst;
    int unsigned edge_n;
    logic        night_after;
    logic [4:0]  cnt;
    logic [2:0]  la;
    logic [2:0]  lb;
    logic        lr;
    logic        e01;
    logic        e23;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input bit rst, input int unsigned e, input logic na,
                              input logic [4:0] c, input logic [2:0] la,
                              input logic [2:0] lb, input logic lr,
                              input logic e01, input logic e23);
    vec_t v;
    v.rst = rst; v.edge_n = e; v.night_after = na; v.cnt = c;
    v.la = la; v.lb = lb; v.lr = lr; v.e01 = e01; v.e23 = e23;
    return v;
  endfunction

  task automatic check(input string name, input int idx, input logic [7:0] act,
                       input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s [%0d]: got %0h, want %0h", name, idx, act, exp);
    end
  endtask

  task automatic step(input int unsigned n);
    repeat (n) @(posedge clk1);
    #1;
    cur += n;
  endtask

  task automatic do_reset();
    night = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk1);
    #1;
    rst_n = 1'b1;
    cur   = 0;
  endtask

  task automatic check_main(input string tag, input int idx, input logic [4:0] c,
                            input logic [2:0] la, input logic [2:0] lb,
                            input logic lr, input logic e01, input logic e23);
    check({tag, ".Count"},  idx, {3'b0, Count},  {3'b0, c});
    check({tag, ".lightA"}, idx, {5'b0, lightA}, {5'b0, la});
    check({tag, ".lightB"}, idx, {5'b0, lightB}, {5'b0, lb});
    check({tag, ".LR1"},    idx, {7'b0, LR1},    {7'b0, lr});
    check({tag, ".eLED01"}, idx, {7'b0, eLED01}, {7'b0, e01});
    check({tag, ".eLED23"}, idx, {7'b0, eLED23}, {7'b0, e23});
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    cur   = 0;
    rst_n = 1'b0;
    night = 1'b0;

    // Reset and a full free-running period
    vecs.push_back(mk(1,  0, 0, 5, LAMP_G, LAMP_R, 0, 1, 0));
    vecs.push_back(mk(0,  4, 0, 4, LAMP_G, LAMP_R, 0, 1, 0));
    vecs.push_back(mk(0, 16, 0, 1, LAMP_G, LAMP_R, 0, 1, 0));
    vecs.push_back(mk(0, 19, 0, 1, LAMP_G, LAMP_R, 0, 1, 0));
    vecs.push_back(mk(0, 20, 0, 2, LAMP_Y, LAMP_R, 0, 1, 0));
    vecs.push_back(mk(0, 24, 0, 1, LAMP_Y, LAMP_R, 0, 1, 0));
    vecs.push_back(mk(0, 27, 0, 1, LAMP_Y, LAMP_R, 0, 1, 0));
    vecs.push_back(mk(0, 28, 0, 5, LAMP_R, LAMP_G, 1, 0, 1));
    vecs.push_back(mk(0, 44, 0, 1, LAMP_R, LAMP_G, 1, 0, 1));
    vecs.push_back(mk(0, 48, 0, 2, LAMP_R, LAMP_Y, 1, 0, 1));
    vecs.push_back(mk(0, 52, 0, 1, LAMP_R, LAMP_Y, 1, 0, 1));
    vecs.push_back(mk(0, 55, 0, 1, LAMP_R, LAMP_Y, 1, 0, 1));
    vecs.push_back(mk(0, 56, 0, 5, LAMP_G, LAMP_R, 0, 1, 0));
    vecs.push_back(mk(0, 60, 0, 4, LAMP_G, LAMP_R, 0, 1, 0));
    // Night mid-phase, flashing, then exit to A_GREEN
    vecs.push_back(mk(1, 10, 1, 3, LAMP_G,   LAMP_R,   0, 1, 0));
    vecs.push_back(mk(0, 11, 1, 0, LAMP_OFF, LAMP_OFF, 0, 0, 0));
    vecs.push_back(mk(0, 14, 1, 0, LAMP_OFF, LAMP_OFF, 0, 0, 0));
    vecs.push_back(mk(0, 15, 1, 0, LAMP_Y,   LAMP_Y,   0, 0, 0));
    vecs.push_back(mk(0, 18, 1, 0, LAMP_Y,   LAMP_Y,   0, 0, 0));
    vecs.push_back(mk(0, 19, 1, 0, LAMP_OFF, LAMP_OFF, 0, 0, 0));
    vecs.push_back(mk(0, 23, 0, 0, LAMP_Y,   LAMP_Y,   0, 0, 0));
    vecs.push_back(mk(0, 24, 0, 5, LAMP_G,   LAMP_R,   0, 1, 0));
    vecs.push_back(mk(0, 27, 0, 5, LAMP_G,   LAMP_R,   0, 1, 0));
    vecs.push_back(mk(0, 28, 0, 4, LAMP_G,   LAMP_R,   0, 1, 0));
    // Night coincident with phase-ending tick
    vecs.push_back(mk(1, 19, 1, 1, LAMP_G,   LAMP_R,   0, 1, 0));
    vecs.push_back(mk(0, 20, 0, 0, LAMP_OFF, LAMP_OFF, 0, 0, 0));
    vecs.push_back(mk(0, 21, 0, 5, LAMP_G,   LAMP_R,   0, 1, 0));
    vecs.push_back(mk(0, 25, 0, 4, LAMP_G,   LAMP_R,   0, 1, 0));
    // Night during road B keeps LR1=1
    vecs.push_back(mk(1, 30, 1, 5, LAMP_R,   LAMP_G,   1, 0, 1));
    vecs.push_back(mk(0, 31, 0, 0, LAMP_OFF, LAMP_OFF, 1, 0, 0));
    vecs.push_back(mk(0, 32, 0, 5, LAMP_G,   LAMP_R,   0, 1, 0));
    vecs.push_back(mk(0, 36, 0, 4, LAMP_G,   LAMP_R,   0, 1, 0));

    foreach (vecs[i]) begin
      if (vecs[i].rst) do_reset();
      if (vecs[i].edge_n > cur) step(vecs[i].edge_n - cur);
      check_main($sformatf("vec@%0d", vecs[i].edge_n), i, vecs[i].cnt, vecs[i].la,
                 vecs[i].lb, vecs[i].lr, vecs[i].e01, vecs[i].e23);
      night = vecs[i].night_after;
    end

    // Asynchronous reset mid-cycle during B_YELLOW
    do_reset();
    step(50);
    check_main("arst.pre", 0, 5'd2, LAMP_R, LAMP_Y, 1'b1, 1'b0, 1'b1);
    #3;
    rst_n = 1'b0;
    #1;
    check_main("arst.low", 0, 5'd5, LAMP_G, LAMP_R, 1'b0, 1'b1, 1'b0);
    #2;
    rst_n = 1'b1;
    cur = 0;
    step(3);
    check_main("arst.e3", 0, 5'd5, LAMP_G, LAMP_R, 1'b0, 1'b1, 1'b0);
    step(1);
    check_main("arst.e4", 0, 5'd4, LAMP_G, LAMP_R, 1'b0, 1'b1, 1'b0);

    // YELLOW_T=1: A_YELLOW holds Count=1 for exactly one tick period
    do_reset();
    check("y1.Count", 0, {3'b0, y_Count}, 8'd5);
    step(19);
    check("y1.Count",  19, {3'b0, y_Count},  8'd1);
    check("y1.lightA", 19, {5'b0, y_lightA}, {5'b0, LAMP_G});
    step(1);
    check("y1.Count",  20, {3'b0, y_Count},  8'd1);
    check("y1.lightA", 20, {5'b0, y_lightA}, {5'b0, LAMP_Y});
    check("y1.lightB", 20, {5'b0, y_lightB}, {5'b0, LAMP_R});
    step(3);
    check("y1.Count",  23, {3'b0, y_Count},  8'd1);
    check("y1.lightA", 23, {5'b0, y_lightA}, {5'b0, LAMP_Y});
    step(1);
    check("y1.Count",  24, {3'b0, y_Count},  8'd5);
    check("y1.lightA", 24, {5'b0, y_lightA}, {5'b0, LAMP_R});
    check("y1.lightB", 24, {5'b0, y_lightB}, {5'b0, LAMP_G});
    check("y1.LR1",    24, {7'b0, y_LR1},    8'd1);
    check("y1.eLED23", 24, {7'b0, y_eLED23}, 8'd1);
    check("y1.eLED01", 24, {7'b0, y_eLED01}, 8'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
